i2s_mic_rx: RTL
===============

Name: i2s_mic_rx

Overview:
- I2S master receiver that produces the audio sample stream consumed by the spectrogram display (ADATA0 / ADATARDY).
- Generates BCLK and LRCLK from the 90 MHz system clock for an external 24-bit I2S MEMS microphone, deserialises the selected channel, and emits a signed 18-bit sample with a one-cycle ready strobe.
- Sits between the board I2S pins and the display block's audio ring buffer.

Parameters:
- BCLK_DIV, 16: CLK cycles per BCLK half-period. Must be even and ≥4. Default gives 2.8125 MHz BCLK and a 43.95 kHz frame rate.
- DATA_BITS, 24: valid data bits per slot, MSB first. Range 18..31.
- CHANNEL, 0: slot captured; 0 = left (LRCLK low), 1 = right.

Ports:
- CLK  in  1  system clock, 90 MHz.
- nRST  in  1  asynchronous active-low reset.
- EN  in  1  run enable; stop is graceful at a frame boundary.
- I2S_BCLK  out  1  bit clock, registered.
- I2S_LRCLK  out  1  word select, registered; low = left slot.
- I2S_SD  in  1  serial data from the microphone, asynchronous to CLK.
- ADATA0  out  18  signed sample, two's complement.
- ADATARDY  out  1  one-CLK pulse when ADATA0 is updated.

Behaviour:
- Reset (async assert, sync release):
  - I2S_BCLK=0, I2S_LRCLK=0, ADATA0=0, ADATARDY=0.
  - Divider, bit counter and shift register all 0; state IDLE.
- States: IDLE, RUN, DRAIN.
  - IDLE: outputs held, BCLK low. EN=1 moves to RUN next cycle.
  - RUN: EN=0 moves to DRAIN.
  - DRAIN: EN=1 returns to RUN with no disturbance. A bitcnt wrap 63→0 moves to IDLE, with BCLK and LRCLK left low and counters cleared.
- Divider (RUN/DRAIN): dcnt counts 0..BCLK_DIV-1. When dcnt=BCLK_DIV-1, BCLK toggles and dcnt returns to 0.
- Falling-edge event (BCLK 1→0):
  - bitcnt (6 bits, mod 64) increments.
  - LRCLK is set to the new bitcnt[5] in the same edge.
  - Slot = bitcnt[5]; in-slot index b = bitcnt[4:0].
- SD input: passes through a 2-flop synchroniser before use.
- Sample point: BCLK=1 and dcnt=BCLK_DIV/2-1 (mid high phase).
  - If slot==CHANNEL and 1≤b≤DATA_BITS, shift the synchronised SD into the LSB of a DATA_BITS shift register.
  - b=1 is the MSB (standard I2S one-bit delay after the WS change).
- Completion: at the sample point with slot==CHANNEL and b==DATA_BITS, on the following CLK edge:
  - ADATA0 = shift[DATA_BITS-1 -: 18], i.e. the top 18 bits, truncated, no rounding.
  - ADATARDY = 1 for exactly one cycle.
- Latency and rate:
  - Last data bit sampled to ADATARDY: 1 CLK.
  - Exactly one ADATARDY per 64·2·BCLK_DIV CLK cycles (2048 at default).
  - ADATA0 is stable between strobes.
- Bits b=0 and b>DATA_BITS, and the non-selected slot, are ignored and the shift register is not modified. The shift register is cleared at b=0 of the selected slot.
- DRAIN still completes a selected-slot word in progress. No partial word is ever emitted.
- Reset mid-frame: everything returns to reset values immediately. No ADATARDY is emitted for the interrupted word.
- BCLK and LRCLK come directly from flops; no combinational glitches.

Decomposition:
- Shared package i2s_pkg:
  - ADATA_W=18, SLOT_BITS=32, FRAME_BITS=64.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module i2s_clkgen: divider, BCLK/LRCLK flops, bitcnt, and the fall/sample strobes plus the slot/b outputs.
- Top level holds the synchroniser, shift register, output register and FSM.

Test Plan:
- Clocking: reset, then EN=1 with defaults → BCLK period 32 CLK at 50% duty, LRCLK period 2048 CLK, LRCLK toggles only on BCLK falling edges, 32 BCLK per LRCLK phase.
- Left word: BFM drives left word 24'hABCDE5 MSB-first, right word 24'hFFFFFF → ADATA0=18'h2AF37 with ADATARDY high exactly one cycle, one CLK after the 24th left sample point; right data never appears.
- Sign and truncation: left 24'h800000 → ADATA0=18'h20000 (−131072); left 24'h00003F → ADATA0=0; left 24'hFFFFC0 → 18'h3FFFF (−1).
- Right channel and width: CHANNEL=1, DATA_BITS=18, right 18'h15555 → ADATA0=18'h15555; strobe spacing 2048 CLK over 10 frames.
- Graceful stop: EN=0 during left bit b=10 → the current word still delivered; then BCLK and LRCLK low at the 63→0 wrap and no further strobes. EN=1 pulse during DRAIN → no gap in BCLK.
- Reset mid-word: nRST low during left b=12 → all outputs 0 asynchronously, no ADATARDY. After release with EN=1, the first strobe comes from a clean frame with correct data.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and FSM state encoding for the I2S microphone receiver.
package i2s_pkg;
  localparam int ADATA_W    = 18;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;
endpackage

// File: rtl/i2s_clkgen.sv
// BCLK/LRCLK generator: divider, frame bit counter, and the sample/wrap strobes
// that tell the receiver where in the frame it is.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 16
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         run,
  output logic                         bclk,
  output logic                         lrclk,
  output logic                         sample,
  output logic                         wrap,
  output logic                         slot,
  output logic [$clog2(SLOT_BITS)-1:0] bidx
);
  localparam int DW = $clog2(BCLK_DIV);
  localparam int CW = $clog2(FRAME_BITS);

  logic [DW-1:0] dcnt_reg;
  logic [CW-1:0] bitcnt_reg;
  logic [CW-1:0] bitcnt_next;
  logic          half_end;
  logic          fall;

  assign half_end    = run && (dcnt_reg == DW'(BCLK_DIV - 1));
  assign fall        = half_end && bclk;
  assign sample      = run && bclk && (dcnt_reg == DW'(BCLK_DIV / 2 - 1));
  assign wrap        = fall && (bitcnt_reg == '1);
  assign bitcnt_next = bitcnt_reg + 1'b1;
  assign slot        = bitcnt_reg[CW-1];
  assign bidx        = bitcnt_reg[CW-2:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dcnt_reg   <= '0;
      bitcnt_reg <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
    end else if (run) begin
      if (half_end) begin
        dcnt_reg <= '0;
        bclk     <= ~bclk;
        // LRCLK follows the slot bit of the incremented count on the same falling edge
        if (bclk) begin
          bitcnt_reg <= bitcnt_next;
          lrclk      <= bitcnt_next[CW-1];
        end
      end else begin
        dcnt_reg <= dcnt_reg + 1'b1;
      end
    end else begin
      dcnt_reg   <= '0;
      bitcnt_reg <= '0;
      bclk       <= 1'b0;
      lrclk      <= 1'b0;
    end
  end
endmodule

// File: rtl/i2s_mic_rx.sv
// I2S master receiver: drives BCLK/LRCLK for a MEMS mic, deserialises one slot
// and emits the top 18 bits as a signed sample with a one-cycle ready strobe.
module i2s_mic_rx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV  = 16,
  parameter int DATA_BITS = 24,
  parameter int CHANNEL   = 0
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               EN,
  output logic               I2S_BCLK,
  output logic               I2S_LRCLK,
  input  logic               I2S_SD,
  output logic [ADATA_W-1:0] ADATA0,
  output logic               ADATARDY
);
  localparam logic [4:0] LAST_B   = 5'(DATA_BITS);
  localparam logic       SEL_SLOT = 1'(CHANNEL);

  state_t               state_reg;
  logic                 run;
  logic                 sample;
  logic                 wrap;
  logic                 slot;
  logic [4:0]           bidx;
  logic                 sel_sample;
  logic [1:0]           sd_sync_reg;
  // Holds all but the final bit; the last bit joins the word on its way to ADATA0.
  logic [DATA_BITS-2:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;

  assign run        = (state_reg != IDLE);
  assign sel_sample = sample && (slot == SEL_SLOT);
  assign shift_next = {shift_reg, sd_sync_reg[1]};

  i2s_clkgen #(
    .BCLK_DIV(BCLK_DIV)
  ) u_clkgen (
    .CLK   (CLK),
    .nRST  (nRST),
    .run   (run),
    .bclk  (I2S_BCLK),
    .lrclk (I2S_LRCLK),
    .sample(sample),
    .wrap  (wrap),
    .slot  (slot),
    .bidx  (bidx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg   <= IDLE;
      sd_sync_reg <= '0;
      shift_reg   <= '0;
      ADATA0      <= '0;
      ADATARDY    <= 1'b0;
    end else begin
      sd_sync_reg <= {sd_sync_reg[0], I2S_SD};
      ADATARDY    <= 1'b0;

      case (state_reg)
        IDLE:    if (EN) state_reg <= RUN;
        RUN:     if (!EN) state_reg <= DRAIN;
        DRAIN: begin
          if (EN)        state_reg <= RUN;
          else if (wrap) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if (sel_sample) begin
        if (bidx == '0) begin
          shift_reg <= '0;
        end else if (bidx <= LAST_B) begin
          shift_reg <= shift_next[DATA_BITS-2:0];
          if (bidx == LAST_B) begin
            ADATA0   <= shift_next[DATA_BITS-1 -: ADATA_W];
            ADATARDY <= 1'b1;
          end
        end
      end
    end
  end
endmodule
